ibex_l2_rf_backing_store: RTL and testbench

- Second-level register storage behind the 8-entry L1 register file (x8-x15); holds every architectural register not resident in L1.
- Accepts tagged read/write requests from the L1 miss/stall logic: x1-x7 map to tags 1-7, x16-x31 map to tags 12-27.
- Reads have fixed, parameterised latency with a valid pulse. Writes are posted through a small write buffer, with read-after-write forwarding from that buffer.

---
 rtl/ibex_l2_rf_backing_store.sv | 255 +++++++++++++++++++++++++
 tb/tb_ibex_l2_rf_backing_store.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_l2_rf_backing_store.sv
`default_nettype none
// ============================================================================
// Module   : ibex_l2_rf_backing_store
// Purpose  : Second-level register storage behind the 8-entry L1 register
//            file. Holds every architectural register not resident in L1
//            (x1-x7 -> tags 1-7, x16-x31 -> tags 12-27). Reads return after
//            a fixed latency with a single-cycle rvalid_o pulse; writes are
//            posted through a small FIFO that drains one entry per cycle and
//            forwards its youngest matching entry to reads.
// Ports    : clk_i, rst_ni (async, active-low)
//            req_i, we_i, addr_i, wdata_i  - tagged request
//            gnt_o                         - request accepted this cycle
//            rvalid_o, rdata_o             - read response (rdata_o=0 idle)
//            err_o                         - out-of-range tag pulse
//            busy_o                        - read in flight / buffer busy
//            rd_cnt_o, wr_cnt_o, fwd_cnt_o - saturating event counters,
//                                            present only when the macro
//                                            IBEX_L2RF_PERF_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module ibex_l2_rf_backing_store #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ENTRIES  = 28,
    parameter int READ_LATENCY = 1,   // 1..4
    parameter int WR_BUF_DEPTH = 2    // 1..4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [4:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  busy_o
`ifdef IBEX_L2RF_PERF_EN
    ,
    output logic [15:0]           rd_cnt_o,
    output logic [15:0]           wr_cnt_o,
    output logic [15:0]           fwd_cnt_o
`endif
);

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_rd_wait = 1'b1;

    localparam int         c_ptr_w     = (WR_BUF_DEPTH > 1) ? $clog2(WR_BUF_DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(WR_BUF_DEPTH - 1);
    localparam logic [2:0] c_buf_depth = 3'(WR_BUF_DEPTH);
    localparam logic [1:0] c_lat_init  = 2'(READ_LATENCY - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [1:0]            r_lat_cnt;
    logic                  r_rvalid;
    logic                  r_rd_err;
    logic                  r_wr_err;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic [DATA_WIDTH-1:0] r_mem      [NUM_ENTRIES];
    logic [4:0]            r_buf_tag  [WR_BUF_DEPTH];
    logic [DATA_WIDTH-1:0] r_buf_data [WR_BUF_DEPTH];
    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic [2:0]            r_occ;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  w_addr_ok;
    logic                  w_drain;
    logic                  w_full;
    logic                  w_gnt_rd;
    logic                  w_gnt_wr;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_enq;
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic [DATA_WIDTH-1:0] w_rd_src;

    assign w_addr_ok = ({27'd0, addr_i} < 32'(NUM_ENTRIES));
    assign w_drain   = (r_occ != 3'd0);
    assign w_full    = (r_occ == c_buf_depth);
    assign w_gnt_rd  = (r_state == c_st_idle);
    // A full buffer always drains this cycle, so a write is in practice
    // always accepted; the expression keeps the FIFO invariant explicit.
    assign w_gnt_wr  = !w_full || w_drain;
    assign w_rd_acc  = req_i && !we_i && w_gnt_rd;
    assign w_wr_acc  = req_i &&  we_i && w_gnt_wr;
    assign w_enq     = w_wr_acc && w_addr_ok;

    assign gnt_o     = rst_ni && req_i && (we_i ? w_gnt_wr : w_gnt_rd);

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        ptr_inc = (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Forwarding: walk the live entries oldest to youngest so the youngest
    // matching tag wins.
    always_comb begin
        int slot;
        slot       = 0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < WR_BUF_DEPTH; i++) begin
            slot = int'(r_head) + i;
            if (slot >= WR_BUF_DEPTH) begin
                slot = slot - WR_BUF_DEPTH;
            end
            if ((3'(i) < r_occ) && (r_buf_tag[slot[c_ptr_w-1:0]] == addr_i)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_buf_data[slot[c_ptr_w-1:0]];
            end
        end
    end

    always_comb begin
        w_rd_src = '0;
        if (w_addr_ok) begin
            w_rd_src = w_fwd_hit ? w_fwd_data : r_mem[addr_i];
        end
    end

    // ------------------------------------------------------------------
    // Read FSM. Data is captured at grant so later writes cannot disturb
    // it. With a latency of 1 the response is produced straight from IDLE,
    // which lets a new read be granted while rvalid_o is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_st_idle;
            r_lat_cnt <= 2'd0;
            r_rvalid  <= 1'b0;
            r_rd_err  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_rd_acc) begin
                        r_rd_data <= w_rd_src;
                        r_rd_err  <= !w_addr_ok;
                        if (c_lat_init == 2'd0) begin
                            r_rvalid <= 1'b1;
                        end else begin
                            r_state   <= c_st_rd_wait;
                            r_lat_cnt <= c_lat_init;
                        end
                    end
                end
                c_st_rd_wait: begin
                    // rvalid_o is high for the cycle in which the counter
                    // sits at 0; the FSM leaves RD_WAIT at the end of it.
                    if (r_lat_cnt == 2'd1) begin
                        r_rvalid <= 1'b1;
                    end
                    if (r_lat_cnt == 2'd0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Posted write buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WR_BUF_DEPTH; i++) begin
                r_buf_tag[i]  <= 5'd0;
                r_buf_data[i] <= '0;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_occ    <= 3'd0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_acc && !w_addr_ok;
            if (w_enq) begin
                r_buf_tag[r_tail]  <= addr_i;
                r_buf_data[r_tail] <= wdata_i;
                r_tail             <= ptr_inc(r_tail);
            end
            if (w_drain) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_enq, w_drain})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Array: only in-range tags are ever enqueued, so the drain index is
    // always legal.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_drain) begin
            r_mem[r_buf_tag[r_head]] <= r_buf_data[r_head];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rvalid ? r_rd_data : '0;
    assign err_o    = (r_rvalid && r_rd_err) || r_wr_err;
    assign busy_o   = (r_state == c_st_rd_wait) || (r_occ != 3'd0);

`ifdef IBEX_L2RF_PERF_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;
    logic [15:0] r_fwd_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_cnt  <= 16'd0;
            r_wr_cnt  <= 16'd0;
            r_fwd_cnt <= 16'd0;
        end else begin
            if (w_rd_acc && (r_rd_cnt != 16'hFFFF)) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_enq && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_rd_acc && w_addr_ok && w_fwd_hit && (r_fwd_cnt != 16'hFFFF)) begin
                r_fwd_cnt <= r_fwd_cnt + 16'd1;
            end
        end
    end

    assign rd_cnt_o  = r_rd_cnt;
    assign wr_cnt_o  = r_wr_cnt;
    assign fwd_cnt_o = r_fwd_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_l2_rf_backing_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_l2_rf_backing_store
// Purpose  : Self-checking bench. Instance 0 uses READ_LATENCY=1 and a
//            2-deep write buffer, instance 1 uses READ_LATENCY=3 and a
//            3-deep buffer. A reference model treats the store as a plain
//            array updated at write grant and read at read grant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_l2_rf_backing_store;

    localparam int NE = 28;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [4:0]  addr  [2];
    logic [31:0] wdata [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];
`ifdef IBEX_L2RF_PERF_EN
    logic [15:0] rd_cnt [2];
    logic [15:0] wr_cnt [2];
    logic [15:0] fwd_cnt[2];
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_mem [2][32];

    always #5 clk = ~clk;

    ibex_l2_rf_backing_store #(
        .DATA_WIDTH(32), .NUM_ENTRIES(NE), .READ_LATENCY(1), .WR_BUF_DEPTH(2)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]), .busy_o(busy[0])
`ifdef IBEX_L2RF_PERF_EN
        , .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0]), .fwd_cnt_o(fwd_cnt[0])
`endif
    );

    ibex_l2_rf_backing_store #(
        .DATA_WIDTH(32), .NUM_ENTRIES(NE), .READ_LATENCY(3), .WR_BUF_DEPTH(3)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]), .busy_o(busy[1])
`ifdef IBEX_L2RF_PERF_EN
        , .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1]), .fwd_cnt_o(fwd_cnt[1])
`endif
    );

    function automatic int rl(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] model_rd(input int k, input logic [4:0] tag);
        return (int'(tag) < NE) ? m_mem[k][tag] : 32'd0;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int t = 0; t < 32; t++) m_mem[k][t] = 32'd0;
    endtask

    // Called at a negedge; returns at the negedge after the grant edge.
    task automatic do_write(input int k, input logic [4:0] tag, input logic [31:0] d);
        req[k] = 1'b1; we[k] = 1'b1; addr[k] = tag; wdata[k] = d;
        #1;
        n_tests++;
        if (gnt[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_gnt inst%0d tag %0d: got %b, required 1", k, tag, gnt[k]);
        end
        @(posedge clk);
        @(negedge clk);
        req[k] = 1'b0; we[k] = 1'b0;
        if (int'(tag) < NE) m_mem[k][tag] = d;
        n_tests++;
        if (err[k] !== (int'(tag) >= NE)) begin
            n_fail++;
            $display("FAIL wr_err inst%0d tag %0d: got %b, required %b", k, tag, err[k], int'(tag) >= NE);
        end
    endtask

    // Called at a negedge; returns at the negedge where rvalid is expected.
    task automatic do_read(input int k, input logic [4:0] tag,
                           output logic [31:0] d, output logic e);
        int t = 0;
        d = 32'd0; e = 1'b0;
        req[k] = 1'b1; we[k] = 1'b0; addr[k] = tag; wdata[k] = $urandom;
        #1;
        while (gnt[k] !== 1'b1 && t < 8) begin
            @(negedge clk); #1; t++;
        end
        n_tests++;
        if (gnt[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_gnt inst%0d tag %0d: got %b, required 1 within 8 cycles", k, tag, gnt[k]);
            req[k] = 1'b0;
            return;
        end
        @(posedge clk);
        for (int n = 1; n <= rl(k); n++) begin
            @(negedge clk);
            if (n == 1) req[k] = 1'b0;
            n_tests++;
            if (n < rl(k)) begin
                if (rvalid[k] !== 1'b0 || rdata[k] !== 32'd0) begin
                    n_fail++;
                    $display("FAIL rd_early inst%0d cyc %0d: got rvalid=%b rdata=%h, required 0/0", k, n, rvalid[k], rdata[k]);
                end
            end else begin
                if (rvalid[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rd_valid inst%0d tag %0d: got %b, required 1", k, tag, rvalid[k]);
                end
                d = rdata[k];
                e = err[k];
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 5'd0; wdata[k] = 32'd0;
        end
        clear_model();
        #3 rst_n = 1'b0;
        req[0] = 1'b1; req[1] = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({gnt[k], rvalid[k], err[k], busy[k]} !== 4'b0000 || rdata[k] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got gnt/rv/err/busy=%b%b%b%b rdata=%h, required 0000/0",
                         k, gnt[k], rvalid[k], err[k], busy[k], rdata[k]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0; req[1] = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_first_read();
        logic [31:0] d; logic e;
        do_read(0, 5'd5, d, e);
        n_tests++;
        if (d !== 32'd0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL first_read: got data=%h err=%b, required 0/0", d, e);
        end
    endtask

    task automatic test_raw();
        logic [31:0] d; logic e;
`ifdef IBEX_L2RF_PERF_EN
        logic [15:0] f0;
        f0 = fwd_cnt[0];
`endif
        for (int k = 0; k < 2; k++) begin
            do_write(k, 5'd12, 32'hDEADBEEF);
            do_read(k, 5'd12, d, e);
            n_tests++;
            if (d !== 32'hDEADBEEF || e !== 1'b0) begin
                n_fail++;
                $display("FAIL raw inst%0d: got %h err=%b, required deadbeef/0", k, d, e);
            end
        end
`ifdef IBEX_L2RF_PERF_EN
        n_tests++;
        if (fwd_cnt[0] !== f0 + 16'd1) begin
            n_fail++;
            $display("FAIL fwd_cnt: got %0d, required %0d", fwd_cnt[0], f0 + 16'd1);
        end
`endif
    endtask

    task automatic test_fill_drain();
        logic [31:0] d; logic e;
        do_write(0, 5'd1, 32'd1);
        do_write(0, 5'd2, 32'd2);
        do_write(0, 5'd3, 32'd3);
        n_tests++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_last_wr: got %b, required 1", busy[0]);
        end
        @(negedge clk);
        n_tests++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_drained: got %b, required 0", busy[0]);
        end
        for (int t = 1; t <= 3; t++) begin
            do_read(0, 5'(t), d, e);
            n_tests++;
            if (d !== model_rd(0, 5'(t))) begin
                n_fail++;
                $display("FAIL fill_rd tag %0d: got %h, required %h", t, d, model_rd(0, 5'(t)));
            end
        end
    endtask

    // Read request held high on the latency-3 instance: two grants.
    task automatic test_latency();
        logic [31:0] exp_d;
        do_write(1, 5'd20, $urandom);
        exp_d = m_mem[1][20];
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 5'd20;
        #1;
        n_tests++;
        if (gnt[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_gnt0: got %b, required 1", gnt[1]);
        end
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n <= 4) begin
                n_tests++;
                if (gnt[1] !== (n == 4)) begin
                    n_fail++;
                    $display("FAIL lat_gnt cyc %0d: got %b, required %b", n, gnt[1], n == 4);
                end
            end
            if (n == 5) req[1] = 1'b0;
            n_tests++;
            if (rvalid[1] !== (n == 3 || n == 7)) begin
                n_fail++;
                $display("FAIL lat_rvalid cyc %0d: got %b, required %b", n, rvalid[1], n == 3 || n == 7);
            end
            if ((n == 3 || n == 7) && rdata[1] !== exp_d) begin
                n_fail++;
                $display("FAIL lat_rdata cyc %0d: got %h, required %h", n, rdata[1], exp_d);
            end
        end
    endtask

    task automatic test_back_to_back();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'd1;
        #1;
        n_tests++;
        if (gnt[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gnt0: got %b, required 1", gnt[0]);
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== model_rd(0, 5'd1) || gnt[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got rv=%b d=%h gnt=%b, required 1/%h/1", rvalid[0], rdata[0], gnt[0], model_rd(0, 5'd1));
        end
        addr[0] = 5'd2;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        n_tests++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== model_rd(0, 5'd2)) begin
            n_fail++;
            $display("FAIL b2b_second: got rv=%b d=%h, required 1/%h", rvalid[0], rdata[0], model_rd(0, 5'd2));
        end
        @(negedge clk);
        n_tests++;
        if (rvalid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse: got %b, required 0", rvalid[0]);
        end
    endtask

    // A write accepted while a read waits must not alter the read's data.
    task automatic test_wr_during_rd();
        logic [31:0] old_d, new_d, d;
        logic        e;
        old_d = m_mem[1][7];
        new_d = ~old_d ^ 32'h5A5A0001;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 5'd7;
        #1;
        @(posedge clk);
        @(negedge clk);
        we[1] = 1'b1; wdata[1] = new_d;
        #1;
        n_tests++;
        if (gnt[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_in_rdwait_gnt: got %b, required 1", gnt[1]);
        end
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0; we[1] = 1'b0;
        m_mem[1][7] = new_d;
        @(negedge clk);
        n_tests++;
        if (rvalid[1] !== 1'b1 || rdata[1] !== old_d) begin
            n_fail++;
            $display("FAIL rd_snapshot: got rv=%b d=%h, required 1/%h", rvalid[1], rdata[1], old_d);
        end
        do_read(1, 5'd7, d, e);
        n_tests++;
        if (d !== new_d) begin
            n_fail++;
            $display("FAIL rd_after_wr: got %h, required %h", d, new_d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic e;
        do_read(0, 5'd30, d, e);
        n_tests++;
        if (d !== 32'd0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_rd: got %h err=%b, required 0/1", d, e);
        end
        do_write(0, 5'd29, 32'h12345678);
        do_read(0, 5'd12, d, e);
        n_tests++;
        if (d !== model_rd(0, 5'd12) || e !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_after: got %h err=%b, required %h/0", d, e, model_rd(0, 5'd12));
        end
        do_read(1, 5'd28, d, e);
        n_tests++;
        if (d !== 32'd0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_edge: got %h err=%b, required 0/1", d, e);
        end
        do_write(1, 5'd27, 32'hCAFE0027);
        do_read(1, 5'd27, d, e);
        n_tests++;
        if (d !== 32'hCAFE0027 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL last_entry: got %h err=%b, required cafe0027/0", d, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] d; logic e;
        logic [4:0]  tag;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 150; i++) begin
                tag = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(28, 31))
                                                  : 5'($urandom_range(0, 27));
                if ($urandom_range(0, 1) == 1) begin
                    do_write(k, tag, $urandom);
                end else begin
                    do_read(k, tag, d, e);
                    n_tests++;
                    if (d !== model_rd(k, tag) || e !== (int'(tag) >= NE)) begin
                        n_fail++;
                        $display("FAIL rand inst%0d op %0d tag %0d: got %h err=%b, required %h/%b",
                                 k, i, tag, d, e, model_rd(k, tag), int'(tag) >= NE);
                    end
                end
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            for (int w = 0; w < 10 && busy[k] !== 1'b0; w++) @(negedge clk);
            n_tests++;
            if (busy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_idle inst%0d: busy got %b, required 0", k, busy[k]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] d; logic e;
        do_write(1, 5'd20, 32'hA5A5_0020);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 5'd9;
        @(posedge clk);
        @(negedge clk);
        we[1] = 1'b1; addr[1] = 5'd4; wdata[1] = 32'h4444;
        @(posedge clk);
        @(negedge clk);
        addr[1] = 5'd5; wdata[1] = 32'h5555;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy[1] !== 1'b0 || rvalid[1] !== 1'b0 || gnt[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: got busy=%b rv=%b gnt=%b, required 0/0/0", busy[1], rvalid[1], gnt[1]);
        end
        req[1] = 1'b0; we[1] = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            n_tests++;
            if (rvalid[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL dropped_read cyc %0d: got rvalid %b, required 0", n, rvalid[1]);
            end
        end
        do_read(1, 5'd20, d, e);
        n_tests++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_20: got %h, required 0", d);
        end
        do_read(1, 5'd4, d, e);
        n_tests++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_4: got %h, required 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_raw();
        test_fill_drain();
        test_latency();
        test_back_to_back();
        test_wr_during_rd();
        test_out_of_range();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
